// File: rtl/mem_arbiter_if.sv
// Bus bundle between the monitor/CPU requesters, the shared block RAM and mem_arbiter.
// Handshake: a requester raises m<n>_req with its payload and holds it until m<n>_gnt is seen high;
// gnt is a one-cycle acknowledge, m<n>_rvalid pulses one cycle after a read grant.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_lock;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_lock;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_write_en;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [1:0]            owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_raddr, ram_waddr, ram_din, ram_write_en,
        input  ram_dout,
        output owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_raddr, ram_waddr, ram_din, ram_write_en,
        output ram_dout,
        input  owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (monitor = port 0, CPU = port 1) for the shared block RAM.
// One access per clock, round-robin or fixed priority, with lock for burst ownership.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter bit FAIR       = 1'b1
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    // Encoding matches the owner output so state is visible directly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t                state;
    logic                  last_gnt;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  gnt0;
    logic                  gnt1;
    logic [ADDR_WIDTH-1:0] sel_addr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.m0_req && bus.m1_req) begin
                        if (FAIR) begin
                            gnt0 = last_gnt;
                            gnt1 = !last_gnt;
                        end else begin
                            gnt0 = 1'b1;
                        end
                    end else begin
                        gnt0 = bus.m0_req;
                        gnt1 = bus.m1_req;
                    end
                end
                OWN0:    gnt0 = bus.m0_req;
                OWN1:    gnt1 = bus.m1_req;
                default: ;
            endcase
        end
    end

    assign sel_addr = gnt1 ? bus.m1_addr : bus.m0_addr;

    // Address lines hold the last granted address when idle so the RAM sees no spurious activity.
    assign bus.ram_raddr    = (gnt0 || gnt1) ? sel_addr : addr_q;
    assign bus.ram_waddr    = (gnt0 || gnt1) ? sel_addr : addr_q;
    assign bus.ram_din      = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    assign bus.ram_write_en = (gnt0 && bus.m0_we) || (gnt1 && bus.m1_we);

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0_q && !rst;
    assign bus.m1_rvalid = rvalid1_q && !rst;
    assign bus.m0_rdata  = bus.ram_dout;
    assign bus.m1_rdata  = bus.ram_dout;
    assign bus.owner     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            rvalid0_q <= gnt0 && !bus.m0_we;
            rvalid1_q <= gnt1 && !bus.m1_we;
            if (gnt0 || gnt1) begin
                last_gnt <= gnt1;
                addr_q   <= sel_addr;
            end
            // Lock is only honoured on the port that actually won this cycle.
            case (state)
                IDLE: begin
                    if (gnt0 && bus.m0_lock)      state <= OWN0;
                    else if (gnt1 && bus.m1_lock) state <= OWN1;
                end
                OWN0:    if (!bus.m0_lock) state <= IDLE;
                OWN1:    if (!bus.m1_lock) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table for arbitration/lock, hand sequences for multi-cycle cases,
// and a read-data scoreboard fed from a reference memory.
module tb_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_p ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIR(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIR(1'b0)) dut_p (
        .clk(clk), .rst(rst), .bus(bus_p.slave));

    // Registered-output block RAM behind the round-robin instance
    logic [DW-1:0] ram_f [0:4095];
    always @(posedge clk) begin
        if (bus.ram_write_en) ram_f[bus.ram_waddr] <= bus.ram_din;
        bus.ram_dout <= ram_f[bus.ram_raddr];
    end

    logic [DW-1:0] ref_mem [0:4095];
    logic [8:0]    exp_q[$];
    int            exp_t_q[$];
    logic [8:0]    mon_e;
    int            mon_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (bus.m0_rvalid || bus.m1_rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                check("rvalid_port", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, mon_e[8] ? 32'd2 : 32'd1);
                check("rdata", mon_e[8] ? bus.m1_rdata : bus.m0_rdata, mon_e[7:0]);
                check("rvalid_latency", cyc, mon_t + 1);
            end
        end
    end

    task automatic drive_port(input int p, input logic req, input logic we, input logic lk,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lk; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lk; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic release_ports();
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Request, wait (bounded) for the grant, and record the expected effect in the model.
    task automatic access(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        logic g;
        n = 0;
        g = 1'b0;
        @(posedge clk); #1;
        drive_port(p, 1'b1, we, 1'b0, a, d);
        while (!g && n < 20) begin
            @(negedge clk);
            g = (p == 0) ? bus.m0_gnt : bus.m1_gnt;
            n++;
        end
        check($sformatf("access_p%0d_grant", p), {31'd0, g}, 32'd1);
        if (g) begin
            if (we) ref_mem[a] = d;
            else begin
                exp_q.push_back({p[0], ref_mem[a]});
                exp_t_q.push_back(cyc);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic r0, l0; logic [AW-1:0] a0;
        logic r1, l1; logic [AW-1:0] a1;
        logic g0, g1, we; logic [AW-1:0] wa; logic [1:0] own;
    } vec_t;

    function automatic vec_t mk(input bit r0, input bit l0, input int a0, input bit r1, input bit l1,
                                input int a1, input bit g0, input bit g1, input bit we, input int wa,
                                input int own);
        vec_t v;
        v.r0 = r0; v.l0 = l0; v.a0 = AW'(a0);
        v.r1 = r1; v.l1 = l1; v.a1 = AW'(a1);
        v.g0 = g0; v.g1 = g1; v.we = we; v.wa = AW'(wa); v.own = 2'(own);
        return v;
    endfunction

    vec_t tbl [15];
    int   pat [6];
    int   k;

    initial begin
        drive_port(0, 1'b1, 1'b1, 1'b0, 12'h010, 8'hEE);
        drive_port(1, 1'b1, 1'b0, 1'b0, 12'h010, 8'h00);
        bus_p.m0_req = 0; bus_p.m0_we = 0; bus_p.m0_lock = 0; bus_p.m0_addr = '0; bus_p.m0_wdata = '0;
        bus_p.m1_req = 0; bus_p.m1_we = 0; bus_p.m1_lock = 0; bus_p.m1_addr = '0; bus_p.m1_wdata = '0;
        bus_p.ram_dout = '0;

        //             r0 l0 a0     r1 l1 a1     g0 g1 we wa     own
        tbl[0]  = mk(1, 0, 'h100, 1, 0, 'h180, 1, 0, 1, 'h100, 0);
        tbl[1]  = mk(1, 0, 'h101, 1, 0, 'h181, 0, 1, 1, 'h181, 0);
        tbl[2]  = mk(1, 0, 'h102, 1, 0, 'h182, 1, 0, 1, 'h102, 0);
        tbl[3]  = mk(1, 0, 'h103, 1, 0, 'h183, 0, 1, 1, 'h183, 0);
        tbl[4]  = mk(0, 0, 'h104, 0, 0, 'h184, 0, 0, 0, 'h183, 0);
        tbl[5]  = mk(0, 0, 'h105, 1, 0, 'h185, 0, 1, 1, 'h185, 0);
        tbl[6]  = mk(1, 0, 'h106, 1, 0, 'h186, 1, 0, 1, 'h106, 0);
        tbl[7]  = mk(1, 0, 'h107, 1, 1, 'h187, 0, 1, 1, 'h187, 0);
        tbl[8]  = mk(1, 0, 'h108, 1, 1, 'h188, 0, 1, 1, 'h188, 2);
        tbl[9]  = mk(1, 0, 'h109, 0, 1, 'h189, 0, 0, 0, 'h188, 2);
        tbl[10] = mk(1, 0, 'h10a, 1, 0, 'h18a, 0, 1, 1, 'h18a, 2);
        tbl[11] = mk(1, 0, 'h10b, 1, 0, 'h18b, 1, 0, 1, 'h10b, 0);
        tbl[12] = mk(1, 1, 'h10c, 1, 0, 'h18c, 0, 1, 1, 'h18c, 0);
        tbl[13] = mk(1, 0, 'h10d, 1, 0, 'h18d, 1, 0, 1, 'h10d, 0);
        tbl[14] = mk(0, 0, 'h10e, 0, 0, 'h18e, 0, 0, 0, 'h10d, 0);

        // Reset with both ports requesting: nothing may be granted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0", {31'd0, bus.m0_gnt}, 32'd0);
        check("rst_gnt1", {31'd0, bus.m1_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        check("rst_write_en", {31'd0, bus.ram_write_en}, 32'd0);
        check("rst_owner", {30'd0, bus.owner}, 32'd0);
        do_reset();

        access(0, 1'b1, 12'h010, 8'hA5);
        release_ports();
        access(1, 1'b0, 12'h010, 8'h00);
        release_ports();

        // Write then immediate read of the same address, back to back on one port
        access(0, 1'b1, 12'h040, 8'h77);
        access(0, 1'b0, 12'h040, 8'h00);
        release_ports();
        repeat (2) @(posedge clk);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drive_port(0, tbl[i].r0, 1'b1, tbl[i].l0, tbl[i].a0, tbl[i].a0[7:0] ^ 8'h5A);
            drive_port(1, tbl[i].r1, 1'b1, tbl[i].l1, tbl[i].a1, tbl[i].a1[7:0] ^ 8'h5A);
            @(negedge clk);
            check($sformatf("vec%0d_gnt0", i), {31'd0, bus.m0_gnt}, {31'd0, tbl[i].g0});
            check($sformatf("vec%0d_gnt1", i), {31'd0, bus.m1_gnt}, {31'd0, tbl[i].g1});
            check($sformatf("vec%0d_write_en", i), {31'd0, bus.ram_write_en}, {31'd0, tbl[i].we});
            check($sformatf("vec%0d_waddr", i), {20'd0, bus.ram_waddr}, {20'd0, tbl[i].wa});
            check($sformatf("vec%0d_raddr", i), {20'd0, bus.ram_raddr}, {20'd0, tbl[i].wa});
            check($sformatf("vec%0d_owner", i), {30'd0, bus.owner}, {30'd0, tbl[i].own});
            if (tbl[i].g0) ref_mem[tbl[i].a0] = tbl[i].a0[7:0] ^ 8'h5A;
            if (tbl[i].g1) ref_mem[tbl[i].a1] = tbl[i].a1[7:0] ^ 8'h5A;
        end
        release_ports();

        // Fixed priority instance: port 0 wins every tie, port 1 gets in when port 0 drops
        @(posedge clk); #1;
        bus_p.m0_req = 1; bus_p.m0_we = 1; bus_p.m0_addr = 12'h200; bus_p.m0_wdata = 8'h01;
        bus_p.m1_req = 1; bus_p.m1_we = 1; bus_p.m1_addr = 12'h280; bus_p.m1_wdata = 8'h02;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("prio%0d_gnt0", i), {31'd0, bus_p.m0_gnt}, 32'd1);
            check($sformatf("prio%0d_gnt1", i), {31'd0, bus_p.m1_gnt}, 32'd0);
        end
        @(posedge clk); #1 bus_p.m0_req = 0;
        @(negedge clk);
        check("prio_drop_gnt1", {31'd0, bus_p.m1_gnt}, 32'd1);
        check("prio_drop_gnt0", {31'd0, bus_p.m0_gnt}, 32'd0);
        @(posedge clk); #1 bus_p.m1_req = 0;

        // Port 0 locked burst with gaps while port 1 keeps asking
        pat = '{1, 0, 1, 0, 1, 1};
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive_port(0, pat[i][0], 1'b1, 1'b1, AW'(k), 8'hC0 + 8'(k));
            drive_port(1, i != 0, 1'b1, 1'b0, 12'h300, 8'h5C);
            @(negedge clk);
            check($sformatf("lock%0d_gnt0", i), {31'd0, bus.m0_gnt}, pat[i]);
            check($sformatf("lock%0d_gnt1", i), {31'd0, bus.m1_gnt}, 32'd0);
            check($sformatf("lock%0d_owner", i), {30'd0, bus.owner}, (i == 0) ? 32'd0 : 32'd1);
            if (pat[i] == 1) begin
                ref_mem[AW'(k)] = 8'hC0 + 8'(k);
                k++;
            end
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("unlock_gnt1", {31'd0, bus.m1_gnt}, 32'd0);
        check("unlock_owner", {30'd0, bus.owner}, 32'd1);
        @(negedge clk);
        check("after_unlock_gnt1", {31'd0, bus.m1_gnt}, 32'd1);
        check("after_unlock_owner", {30'd0, bus.owner}, 32'd0);
        ref_mem[12'h300] = 8'h5C;
        release_ports();
        for (int i = 0; i < 4; i++) access(1, 1'b0, AW'(i), 8'h00);
        access(1, 1'b0, 12'h300, 8'h00);
        release_ports();
        repeat (2) @(posedge clk);

        // Reset arriving the cycle after a read grant swallows the read data
        @(posedge clk); #1;
        drive_port(1, 1'b1, 1'b0, 1'b0, 12'h010, 8'h00);
        @(negedge clk);
        check("rstread_gnt1", {31'd0, bus.m1_gnt}, 32'd1);
        @(posedge clk); #1;
        drive_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rstread%0d_rvalid", i), {31'd0, bus.m1_rvalid}, 32'd0);
            check($sformatf("rstread%0d_write_en", i), {31'd0, bus.ram_write_en}, 32'd0);
            check($sformatf("rstread%0d_owner", i), {30'd0, bus.owner}, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Idle period after a write must not disturb the RAM
        access(0, 1'b1, 12'h020, 8'h3C);
        release_ports();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d_write_en", i), {31'd0, bus.ram_write_en}, 32'd0);
        end
        access(1, 1'b0, 12'h020, 8'h00);
        access(1, 1'b0, 12'h010, 8'h00);
        access(1, 1'b0, 12'h101, 8'h00);
        release_ports();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
